// File: rtl/encoder_32to5_pending_if.sv
// Request/grant bundle for the 32-to-5 pending priority encoder.
// The master side drives requests, masks and the ack; the slave side
// (the encoder) returns the presented index, grant pulse and pending count.
interface encoder_32to5_pending_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
);
    logic               en;
    logic [0:WIDTH-1]   req_in;
    logic [0:WIDTH-1]   mask_in;
    logic               flush;
    logic               ack;
    logic               valid_out;
    logic [IDX_W-1:0]   idx_out;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W:0]     pend_cnt;

    modport master (
        output en, req_in, mask_in, flush, ack,
        input  valid_out, idx_out, grant_valid, grant_idx, pend_cnt
    );

    modport slave (
        input  en, req_in, mask_in, flush, ack,
        output valid_out, idx_out, grant_valid, grant_idx, pend_cnt
    );
endinterface

// File: rtl/encoder_32to5_pending.sv
// Sequenced 32-to-5 priority encoder with a pending-request register.
// Request pulses are latched into a pending vector; the lowest-numbered
// unmasked pending source is presented as a binary index and retired when
// the consumer acks it. Masked sources stay pending and keep counting.
module encoder_32to5_pending #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input logic                     clk,
    input logic                     reset,
    encoder_32to5_pending_if.slave  bus
);

    logic [0:WIDTH-1]   pend_r;
    logic               grant_valid_r;
    logic [IDX_W-1:0]   grant_idx_r;
    logic [IDX_W:0]     pend_cnt_r;

    logic [0:WIDTH-1]   vis_s;
    logic               valid_s;
    logic [IDX_W-1:0]   idx_s;
    logic               accept_s;
    logic [0:WIDTH-1]   clr_s;
    logic [0:WIDTH-1]   pend_nxt_s;

    // Index of the lowest set bit; scanning downward lets the lowest win.
    function automatic logic [IDX_W-1:0] lowest_index(input logic [0:WIDTH-1] v);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Number of set bits in a request-sized vector.
    function automatic logic [IDX_W:0] popcount(input logic [0:WIDTH-1] v);
        logic [IDX_W:0] cnt;
        cnt = {(IDX_W + 1){1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + {{IDX_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // Presented index, accept decision and next pending vector.
    always_comb begin
        vis_s   = pend_r & ~bus.mask_in;
        valid_s = bus.en & (|vis_s);
        if (valid_s) begin
            idx_s = lowest_index(vis_s);
        end else begin
            idx_s = {IDX_W{1'b0}};
        end
        // Flush outranks ack, so an ack in a flush cycle is never accepted.
        accept_s = valid_s & bus.ack & ~bus.flush;
        clr_s    = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            clr_s[i] = accept_s & (idx_s == IDX_W'(i));
        end
        // Set wins: a request on the bit being acked keeps it pending.
        if (bus.flush) begin
            pend_nxt_s = {WIDTH{1'b0}};
        end else begin
            pend_nxt_s = (pend_r & ~clr_s) | bus.req_in;
        end
    end

    // Pending vector, grant record and population count.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_r        <= {WIDTH{1'b0}};
            grant_valid_r <= 1'b0;
            grant_idx_r   <= {IDX_W{1'b0}};
            pend_cnt_r    <= {(IDX_W + 1){1'b0}};
        end else begin
            pend_r        <= pend_nxt_s;
            grant_valid_r <= accept_s;
            if (accept_s) begin
                grant_idx_r <= idx_s;
            end else begin
                grant_idx_r <= grant_idx_r;
            end
            // Count of the next pending value keeps pend_cnt equal to popcount(P).
            pend_cnt_r    <= popcount(pend_nxt_s);
        end
    end

    assign bus.valid_out   = valid_s;
    assign bus.idx_out     = idx_s;
    assign bus.grant_valid = grant_valid_r;
    assign bus.grant_idx   = grant_idx_r;
    assign bus.pend_cnt    = pend_cnt_r;

endmodule

// File: tb/tb_encoder_32to5_pending.sv
// Self-checking bench for encoder_32to5_pending: directed scenarios from the
// feature list followed by randomized traffic against a behavioural model.
module tb_encoder_32to5_pending;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    encoder_32to5_pending_if bus ();

    encoder_32to5_pending dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: a set of pending source numbers plus the last grant.
    bit m_pend [32];
    bit m_gv;
    int m_gidx;

    // Lowest visible pending source, or -1 when nothing would be presented.
    function automatic int model_idx();
        if (!bus.en) return -1;
        for (int i = 0; i < 32; i++) begin
            if (m_pend[i] && !bus.mask_in[i]) return i;
        end
        return -1;
    endfunction

    function automatic int model_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    // Advance one clock and apply the spec's next-state rules to the model.
    task automatic step();
        int  e;
        bit  acc;
        e   = model_idx();
        acc = bus.ack && (e >= 0);
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
            m_gv   = 1'b0;
            m_gidx = 0;
        end else if (bus.flush) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
            m_gv = 1'b0;
        end else begin
            if (acc) m_pend[e] = 1'b0;
            for (int i = 0; i < 32; i++) if (bus.req_in[i]) m_pend[i] = 1'b1;
            m_gv = acc;
            if (acc) m_gidx = e;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_in = {32{1'b1}};
        step();
        step();
        reset = 1'b0;
        bus.req_in = {32{1'b0}};
        #1;
        n_cmp++; if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", bus.valid_out); end
        n_cmp++; if (bus.idx_out !== 5'd0) begin n_bad++; $display("FAIL reset_idx got %0d want 0", bus.idx_out); end
        n_cmp++; if (bus.pend_cnt !== 6'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", bus.pend_cnt); end
        n_cmp++; if (bus.grant_valid !== 1'b0) begin n_bad++; $display("FAIL reset_gv got %0b want 0", bus.grant_valid); end
        n_cmp++; if (bus.grant_idx !== 5'd0) begin n_bad++; $display("FAIL reset_gidx got %0d want 0", bus.grant_idx); end
        step();
        n_cmp++; if (bus.pend_cnt !== 6'd0) begin n_bad++; $display("FAIL reset_cnt_after got %0d want 0", bus.pend_cnt); end
    endtask

    task automatic test_priority_drain();
        bus.req_in = {32{1'b0}};
        bus.req_in[3] = 1'b1; bus.req_in[17] = 1'b1; bus.req_in[31] = 1'b1;
        step();
        bus.req_in = {32{1'b0}};
        #1;
        n_cmp++; if (bus.idx_out !== 5'd3) begin n_bad++; $display("FAIL drain_idx0 got %0d want 3", bus.idx_out); end
        n_cmp++; if (bus.pend_cnt !== 6'd3) begin n_bad++; $display("FAIL drain_cnt0 got %0d want 3", bus.pend_cnt); end
        n_cmp++; if (bus.valid_out !== 1'b1) begin n_bad++; $display("FAIL drain_valid0 got %0b want 1", bus.valid_out); end
        bus.ack = 1'b1;
        step();
        n_cmp++; if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 5'd3) begin n_bad++; $display("FAIL drain_g1 got %0b/%0d want 1/3", bus.grant_valid, bus.grant_idx); end
        n_cmp++; if (bus.idx_out !== 5'd17) begin n_bad++; $display("FAIL drain_idx1 got %0d want 17", bus.idx_out); end
        step();
        n_cmp++; if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 5'd17) begin n_bad++; $display("FAIL drain_g2 got %0b/%0d want 1/17", bus.grant_valid, bus.grant_idx); end
        n_cmp++; if (bus.idx_out !== 5'd31) begin n_bad++; $display("FAIL drain_idx2 got %0d want 31", bus.idx_out); end
        step();
        n_cmp++; if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 5'd31) begin n_bad++; $display("FAIL drain_g3 got %0b/%0d want 1/31", bus.grant_valid, bus.grant_idx); end
        n_cmp++; if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL drain_valid_end got %0b want 0", bus.valid_out); end
        n_cmp++; if (bus.pend_cnt !== 6'd0) begin n_bad++; $display("FAIL drain_cnt_end got %0d want 0", bus.pend_cnt); end
        step();
        n_cmp++; if (bus.grant_valid !== 1'b0 || bus.grant_idx !== 5'd31) begin n_bad++; $display("FAIL drain_idle_ack got %0b/%0d want 0/31", bus.grant_valid, bus.grant_idx); end
        bus.ack = 1'b0;
    endtask

    task automatic test_mask();
        bus.req_in = {32{1'b0}};
        bus.req_in[0] = 1'b1; bus.req_in[5] = 1'b1;
        step();
        bus.req_in = {32{1'b0}};
        bus.mask_in[0] = 1'b1;
        #1;
        n_cmp++; if (bus.idx_out !== 5'd5) begin n_bad++; $display("FAIL mask_idx got %0d want 5", bus.idx_out); end
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        #1;
        n_cmp++; if (bus.pend_cnt !== 6'd1) begin n_bad++; $display("FAIL mask_cnt got %0d want 1", bus.pend_cnt); end
        n_cmp++; if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL mask_valid got %0b want 0", bus.valid_out); end
        n_cmp++; if (bus.grant_idx !== 5'd5) begin n_bad++; $display("FAIL mask_gidx got %0d want 5", bus.grant_idx); end
        bus.mask_in = {32{1'b0}};
        #1;
        n_cmp++; if (bus.valid_out !== 1'b1 || bus.idx_out !== 5'd0) begin n_bad++; $display("FAIL mask_clear got %0b/%0d want 1/0", bus.valid_out, bus.idx_out); end
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
    endtask

    task automatic test_set_wins();
        bus.req_in = {32{1'b0}};
        bus.req_in[9] = 1'b1;
        step();
        bus.ack = 1'b1;
        step();
        bus.req_in = {32{1'b0}};
        bus.ack = 1'b0;
        #1;
        n_cmp++; if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 5'd9) begin n_bad++; $display("FAIL setwins_grant got %0b/%0d want 1/9", bus.grant_valid, bus.grant_idx); end
        n_cmp++; if (bus.pend_cnt !== 6'd1) begin n_bad++; $display("FAIL setwins_cnt got %0d want 1", bus.pend_cnt); end
        n_cmp++; if (bus.valid_out !== 1'b1 || bus.idx_out !== 5'd9) begin n_bad++; $display("FAIL setwins_pending got %0b/%0d want 1/9", bus.valid_out, bus.idx_out); end
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
    endtask

    task automatic test_flush();
        bus.req_in = {32{1'b0}};
        bus.req_in[1] = 1'b1; bus.req_in[4] = 1'b1; bus.req_in[6] = 1'b1; bus.req_in[20] = 1'b1;
        step();
        n_cmp++; if (bus.pend_cnt !== 6'd4) begin n_bad++; $display("FAIL flush_pre_cnt got %0d want 4", bus.pend_cnt); end
        bus.req_in = {32{1'b0}};
        bus.req_in[2] = 1'b1;
        bus.flush = 1'b1;
        bus.ack = 1'b1;
        step();
        bus.req_in = {32{1'b0}};
        bus.flush = 1'b0;
        bus.ack = 1'b0;
        #1;
        n_cmp++; if (bus.grant_valid !== 1'b0) begin n_bad++; $display("FAIL flush_gv got %0b want 0", bus.grant_valid); end
        n_cmp++; if (bus.pend_cnt !== 6'd0) begin n_bad++; $display("FAIL flush_cnt got %0d want 0", bus.pend_cnt); end
        n_cmp++; if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL flush_valid got %0b want 0", bus.valid_out); end
        n_cmp++; if (bus.grant_idx !== 5'(m_gidx)) begin n_bad++; $display("FAIL flush_gidx_hold got %0d want %0d", bus.grant_idx, m_gidx); end
    endtask

    task automatic test_enable();
        bus.en = 1'b0;
        bus.req_in = {32{1'b0}};
        bus.req_in[12] = 1'b1;
        step();
        bus.req_in = {32{1'b0}};
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        #1;
        n_cmp++; if (bus.pend_cnt !== 6'd1) begin n_bad++; $display("FAIL en_cnt got %0d want 1", bus.pend_cnt); end
        n_cmp++; if (bus.grant_valid !== 1'b0) begin n_bad++; $display("FAIL en_gv got %0b want 0", bus.grant_valid); end
        n_cmp++; if (bus.valid_out !== 1'b0 || bus.idx_out !== 5'd0) begin n_bad++; $display("FAIL en_low got %0b/%0d want 0/0", bus.valid_out, bus.idx_out); end
        bus.en = 1'b1;
        #1;
        n_cmp++; if (bus.valid_out !== 1'b1 || bus.idx_out !== 5'd12) begin n_bad++; $display("FAIL en_high got %0b/%0d want 1/12", bus.valid_out, bus.idx_out); end
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
    endtask

    task automatic test_random();
        int       e;
        logic [4:0] exp_idx;
        for (int n = 0; n < 400; n++) begin
            bus.req_in  = ($urandom_range(0, 3) == 0) ? ($urandom() & $urandom() & $urandom()) : {32{1'b0}};
            bus.mask_in = ($urandom_range(0, 2) == 0) ? ($urandom() & $urandom()) : {32{1'b0}};
            bus.en      = ($urandom_range(0, 7) != 0);
            bus.ack     = ($urandom_range(0, 1) == 1);
            bus.flush   = ($urandom_range(0, 19) == 0);
            reset       = ($urandom_range(0, 99) == 0);
            #1;
            e = model_idx();
            exp_idx = (e >= 0) ? e[4:0] : 5'd0;
            n_cmp++; if (bus.valid_out !== (e >= 0)) begin n_bad++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", n, bus.valid_out, (e >= 0)); end
            n_cmp++; if (bus.idx_out !== exp_idx) begin n_bad++; $display("FAIL rnd_idx cyc %0d got %0d want %0d", n, bus.idx_out, exp_idx); end
            step();
            n_cmp++; if (bus.grant_valid !== m_gv) begin n_bad++; $display("FAIL rnd_gv cyc %0d got %0b want %0b", n, bus.grant_valid, m_gv); end
            n_cmp++; if (bus.grant_idx !== 5'(m_gidx)) begin n_bad++; $display("FAIL rnd_gidx cyc %0d got %0d want %0d", n, bus.grant_idx, m_gidx); end
            n_cmp++; if (bus.pend_cnt !== 6'(model_cnt())) begin n_bad++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", n, bus.pend_cnt, model_cnt()); end
        end
        reset     = 1'b0;
        bus.flush = 1'b0;
        bus.ack   = 1'b0;
        bus.req_in = {32{1'b0}};
    endtask

    initial begin
        reset       = 1'b0;
        bus.en      = 1'b1;
        bus.req_in  = {32{1'b0}};
        bus.mask_in = {32{1'b0}};
        bus.flush   = 1'b0;
        bus.ack     = 1'b0;
        m_gv        = 1'b0;
        m_gidx      = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        @(negedge clk);
        test_reset();
        test_priority_drain();
        test_mask();
        test_set_wins();
        test_flush();
        test_enable();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
